// File: rtl/bcd_counter_nd.sv
// N-digit cascaded BCD counter with up/down mode, clamped parallel load,
// a registered wrap pulse and a registered all-zero flag.
module bcd_counter_nd #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned TOP_MOD = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   data,
    output logic                  t,
    output logic                  zero,
    output logic                  load_err
);

    localparam int unsigned W       = 4 * DIGITS;
    localparam logic [3:0]  TOP_MAX = 4'(TOP_MOD - 1);
    localparam logic [3:0]  LOW_MAX = 4'd9;

    logic [W-1:0] data_q, data_d;
    logic         t_q, t_d;
    logic         zero_q, zero_d;
    logic         load_err_q, load_err_d;

    // Per-digit scratch used while building the next value
    logic [3:0]   dig_c;
    logic [3:0]   max_c;
    logic         step_c;

    // Highest digit uses the configurable modulus, all others count 0..9
    function automatic logic [3:0] digit_max(input int unsigned k);
        return (k == DIGITS - 1) ? TOP_MAX : LOW_MAX;
    endfunction

    // Next-state: clr > load > en > hold (rst handled in the register)
    always_comb begin
        data_d     = data_q;
        t_d        = 1'b0;
        load_err_d = 1'b0;
        dig_c      = 4'd0;
        max_c      = 4'd0;
        step_c     = 1'b0;

        if (clr) begin
            data_d = '0;
        end else if (load) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                dig_c = load_val[4*k +: 4];
                max_c = digit_max(k);
                if (dig_c > max_c) begin
                    dig_c      = max_c;
                    load_err_d = 1'b1;
                end
                data_d[4*k +: 4] = dig_c;
            end
        end else if (en) begin
            // step_c ripples upward while every lower digit sits at its wrap point
            step_c = 1'b1;
            for (int unsigned k = 0; k < DIGITS; k++) begin
                dig_c = data_q[4*k +: 4];
                max_c = digit_max(k);
                if (step_c) begin
                    if (up) begin
                        if (dig_c == max_c) begin
                            dig_c = 4'd0;
                        end else begin
                            dig_c  = dig_c + 4'd1;
                            step_c = 1'b0;
                        end
                    end else begin
                        if (dig_c == 4'd0) begin
                            dig_c = max_c;
                        end else begin
                            dig_c  = dig_c - 4'd1;
                            step_c = 1'b0;
                        end
                    end
                end
                data_d[4*k +: 4] = dig_c;
            end
            // Ripple surviving past the top digit means the whole counter wrapped
            t_d = step_c;
        end

        zero_d = (data_d == '0);
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            t_q        <= 1'b0;
            zero_q     <= 1'b1;
            load_err_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            t_q        <= t_d;
            zero_q     <= zero_d;
            load_err_q <= load_err_d;
        end
    end

    assign data     = data_q;
    assign t        = t_q;
    assign zero     = zero_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Bench for bcd_counter_nd: a 2-digit mod-60 instance and a 4-digit decimal
// instance share control inputs; an integer-valued model predicts both.
module tb_bcd_counter_nd;

    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, clr = 1'b0, up = 1'b1, load = 1'b0;
    logic [15:0] load_val = 16'h0;

    logic [7:0]  d2;
    logic        t2, z2, e2;
    logic [15:0] d4;
    logic        t4, z4, e4;

    int checks   = 0;
    int failures = 0;

    // Model state: counter value as a plain integer, plus pulse expectations
    int n2 = 0, n4 = 0;
    bit mt2 = 0, mt4 = 0, me2 = 0, me4 = 0;
    bit valid = 0;

    always #5 clk = ~clk;

    bcd_counter_nd #(.DIGITS(2), .TOP_MOD(6)) u2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up(up), .load(load),
        .load_val(load_val[7:0]), .data(d2), .t(t2), .zero(z2), .load_err(e2)
    );

    bcd_counter_nd #(.DIGITS(4), .TOP_MOD(10)) u4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up(up), .load(load),
        .load_val(load_val), .data(d4), .t(t4), .zero(z4), .load_err(e4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int n, input int d);
        logic [31:0] r = '0;
        int v = n;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One model step for a counter of d digits whose top digit has modulus top
    task automatic model_step(input int d, input int top, input logic [15:0] lv,
                              inout int n, inout bit tt, inout bit ee);
        int modulus = top;
        for (int k = 1; k < d; k++) modulus = modulus * 10;
        tt = 0;
        ee = 0;
        if (rst || clr) begin
            n = 0;
        end else if (load) begin
            int sum = 0, scale = 1;
            for (int k = 0; k < d; k++) begin
                int dg = int'(lv[4*k +: 4]);
                int mx = (k == d - 1) ? top - 1 : 9;
                if (dg > mx) begin dg = mx; ee = 1; end
                sum   = sum + dg * scale;
                scale = scale * 10;
            end
            n = sum;
        end else if (en) begin
            if (up) begin
                tt = (n == modulus - 1);
                n  = (n + 1) % modulus;
            end else begin
                tt = (n == 0);
                n  = (n + modulus - 1) % modulus;
            end
        end
    endtask

    // One clock: DUT and model consume the same sampled inputs
    task automatic step();
        @(posedge clk);
        model_step(2, 6,  load_val, n2, mt2, me2);
        model_step(4, 10, load_val, n4, mt4, me4);
        if (rst) valid = 1;
        #1;
    endtask

    task automatic idle_ctl();
        rst = 0; clr = 0; load = 0; en = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        idle_ctl();
        load = 1; load_val = v;
        step();
        load = 0;
    endtask

    // Compare process: every falling edge once reset has been applied
    always @(negedge clk) begin
        if (valid) begin
            chk("u2_data", 32'(d2), to_bcd(n2, 2));
            chk("u2_t",    32'(t2), 32'(mt2));
            chk("u2_zero", 32'(z2), 32'(n2 == 0));
            chk("u2_err",  32'(e2), 32'(me2));
            chk("u4_data", 32'(d4), to_bcd(n4, 4));
            chk("u4_t",    32'(t4), 32'(mt4));
            chk("u4_zero", 32'(z4), 32'(n4 == 0));
            chk("u4_err",  32'(e4), 32'(me4));
        end
    end

    initial begin
        // Reset
        rst = 1; step(); rst = 0;
        chk("rst_data", 32'(d4), 32'h0);
        chk("rst_zero", 32'(z4), 32'h1);
        chk("rst_t",    32'(t4), 32'h0);
        chk("rst_err",  32'(e4), 32'h0);

        // Mod-60 wrap up
        en = 1; up = 1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 59) chk("m60_59", 32'(d2), 32'h59);
        end
        chk("m60_wrap_data", 32'(d2), 32'h00);
        chk("m60_wrap_t",    32'(t2), 32'h1);
        chk("m60_wrap_zero", 32'(z2), 32'h1);
        chk("m60_u4_60",     32'(d4), 32'h0060);
        step();
        chk("m60_after_t",   32'(t2), 32'h0);
        chk("m60_after",     32'(d2), 32'h01);

        // Borrow down
        do_load(16'h0001);
        en = 1; up = 0;
        step(); chk("bor_00",   32'(d2), 32'h00);
        step(); chk("bor_59",   32'(d2), 32'h59);
                chk("bor_59_t", 32'(t2), 32'h1);
        step(); chk("bor_58",   32'(d2), 32'h58);
                chk("bor_58_t", 32'(t2), 32'h0);

        // Clamp
        do_load(16'hA3F7);
        chk("clamp_u4",     32'(d4), 32'h9397);
        chk("clamp_u4_err", 32'(e4), 32'h1);
        chk("clamp_u2",     32'(d2), 32'h57);
        do_load(16'h1234);
        chk("noclamp_u4",   32'(d4), 32'h1234);
        chk("noclamp_err",  32'(e4), 32'h0);

        // Priority
        do_load(16'h0042);
        clr = 1; load = 1; en = 1; up = 1; load_val = 16'h0042;
        step(); idle_ctl();
        chk("prio_clr_data", 32'(d4), 32'h0);
        chk("prio_clr_t",    32'(t4), 32'h0);
        chk("prio_clr_err",  32'(e4), 32'h0);
        load = 1; en = 1; load_val = 16'h0005;
        step(); idle_ctl();
        chk("prio_load", 32'(d4), 32'h0005);

        // Reset at wrap
        do_load(16'h9999);
        rst = 1; en = 1; up = 1;
        step(); idle_ctl();
        chk("rstwrap_data", 32'(d4), 32'h0);
        chk("rstwrap_t",    32'(t4), 32'h0);
        do_load(16'h9999);
        en = 1; up = 1;
        step(); idle_ctl();
        chk("wrap_data", 32'(d4), 32'h0);
        chk("wrap_t",    32'(t4), 32'h1);

        // Hold and direction flip
        do_load(16'h0109);
        en = 1; up = 1;
        step(); chk("flip_up", 32'(d4), 32'h0110);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_data", 32'(d4), 32'h0110);
            chk("hold_t",    32'(t4), 32'h0);
        end
        en = 1; up = 0;
        step(); chk("flip_down", 32'(d4), 32'h0109);

        // Randomised traffic, mostly counting so wraps of the mod-60 instance occur
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            clr  = ($urandom_range(0, 59) == 0);
            load = ($urandom_range(0, 19) == 0);
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) up = ~up;
            load_val = 16'($urandom);
            if ($urandom_range(0, 3) == 0) load_val = 16'h9959;
            step();
        end
        idle_ctl();

        // Long decimal run down through the 4-digit borrow
        do_load(16'h0003);
        en = 1; up = 0;
        for (int i = 0; i < 6; i++) step();
        chk("u4_borrow", 32'(d4), 32'h9997);
        idle_ctl();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
